// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that feeds a UART transmitter one frame at a time,
// waiting for each frame to complete and optionally idling GAP_CYCLES clocks between frames.
module uart_tx_feeder #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_ovf,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ADDR_W:0]  LVL_FULL = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;
  state_t            r_state;
  logic [7:0]        r_tx_data;
  logic              r_tx_send;
  logic [GAP_W-1:0]  r_gap_cnt;

  logic              w_push;
  logic              w_pop;
  logic [ADDR_W:0]   w_level_nxt;

  assign w_push = wr_en && !r_full;
  // The pop is the IDLE->SEND launch; it uses the registered empty flag.
  assign w_pop  = (r_state == S_IDLE) && !r_empty && !tx_active;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + 1'b1;
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_FULL);
      r_empty <= (w_level_nxt == '0);
      // A dropped write outranks a clear in the same cycle.
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tx_data <= '0;
      r_tx_send <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tx_data <= r_mem[r_rd_ptr];
            r_tx_send <= 1'b1;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_active) begin
            r_tx_send <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!tx_active && tx_done) begin
            if (GAP_CYCLES > 0) begin
              r_gap_cnt <= GAP_LOAD;
              r_state   <= S_GAP;
            end else begin
              r_state   <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_send   = r_tx_send;
  assign full      = r_full;
  assign empty     = r_empty;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: two instances (no gap, gap of 4) driven by directed steps,
// with a transmitter responder and a byte-order scoreboard.
module tb_uart_tx_feeder;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int GAP    = 4;

  logic clk;
  logic reset;
  logic [1:0]             wr_en;
  logic [1:0][7:0]        wr_data;
  logic [1:0]             clr_ovf;
  logic [1:0]             tx_active;
  logic [1:0]             tx_done;
  logic [1:0][7:0]        tx_data_o;
  logic [1:0]             tx_send_o;
  logic [1:0]             full_o;
  logic [1:0]             empty_o;
  logic [1:0][ADDR_W:0]   level_o;
  logic [1:0]             overflow_o;
  logic [1:0]             busy_o;
  logic [1:0][1:0]        state_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: expected send order, stored-byte count and sticky overflow.
  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];
  int m_lvl[2];
  logic [1:0] m_ovf;

  // Transmitter responder state and frame timing records.
  logic [1:0] auto_on;
  int act_cnt[2];
  int sent_cnt[2];
  int rise0_q[$], exit0_q[$], rise1_q[$], exit1_q[$];

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en[0]), .wr_data(wr_data[0]), .clr_ovf(clr_ovf[0]),
    .tx_active(tx_active[0]), .tx_done(tx_done[0]), .tx_data(tx_data_o[0]), .tx_send(tx_send_o[0]),
    .full(full_o[0]), .empty(empty_o[0]), .level(level_o[0]), .overflow(overflow_o[0]),
    .busy(busy_o[0]), .dbg_state(state_o[0])
  );

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP)) u_dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en[1]), .wr_data(wr_data[1]), .clr_ovf(clr_ovf[1]),
    .tx_active(tx_active[1]), .tx_done(tx_done[1]), .tx_data(tx_data_o[1]), .tx_send(tx_send_o[1]),
    .full(full_o[1]), .empty(empty_o[1]), .level(level_o[1]), .overflow(overflow_o[1]),
    .busy(busy_o[1]), .dbg_state(state_o[1])
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_size(input int d);
    return (d == 0) ? exp0_q.size() : exp1_q.size();
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One clock of write/clear stimulus, with the model updated from the rules.
  task automatic drive(input int d, input logic we, input logic [7:0] b, input logic clr);
    wr_en[d]   = we;
    wr_data[d] = b;
    clr_ovf[d] = clr;
    if (we && m_lvl[d] >= DEPTH) m_ovf[d] = 1'b1;
    else if (clr) m_ovf[d] = 1'b0;
    if (we && m_lvl[d] < DEPTH) begin
      m_lvl[d]++;
      if (d == 0) exp0_q.push_back(b);
      else exp1_q.push_back(b);
    end
    tick();
    wr_en[d]   = 1'b0;
    clr_ovf[d] = 1'b0;
  endtask

  task automatic chk_fifo(input int d, input string tag);
    chk({tag, "_level"}, 32'(level_o[d]), 32'(m_lvl[d]));
    chk({tag, "_full"}, 32'(full_o[d]), 32'(m_lvl[d] == DEPTH));
    chk({tag, "_empty"}, 32'(empty_o[d]), 32'(m_lvl[d] == 0));
    chk({tag, "_ovf"}, 32'(overflow_o[d]), 32'(m_ovf[d]));
  endtask

  task automatic wait_idle(input int d, input string tag);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (exp_size(d) == 0 && !busy_o[d] && act_cnt[d] == 0 && !tx_done[d]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_drained"}, 32'(ok), 32'd1);
  endtask

  task automatic stall(input int d);
    auto_on[d]   = 1'b0;
    tx_done[d]   = 1'b0;
    tx_active[d] = 1'b1;
  endtask

  task automatic release_tx(input int d);
    tx_active[d] = 1'b0;
    tx_done[d]   = 1'b0;
    act_cnt[d]   = 0;
    auto_on[d]   = 1'b1;
  endtask

  // Transmitter model: active for 10 clocks starting one clock after tx_send, then a done pulse.
  initial begin
    auto_on = '0;
    act_cnt[0] = 0; act_cnt[1] = 0;
    sent_cnt[0] = 0; sent_cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (auto_on[d]) begin
          if (act_cnt[d] > 0) begin
            act_cnt[d]--;
            if (act_cnt[d] == 0) begin
              tx_active[d] = 1'b0;
              tx_done[d]   = 1'b1;
              if (d == 0) exit0_q.push_back(cyc + 1);
              else exit1_q.push_back(cyc + 1);
            end
          end else begin
            tx_done[d] = 1'b0;
            if (tx_send_o[d] === 1'b1) begin
              sent_cnt[d]++;
              m_lvl[d]--;
              if (exp_size(d) == 0) begin
                chk("unexpected_frame", 32'(tx_data_o[d]), 32'hFFFF_FFFF);
              end else if (d == 0) begin
                chk("frame_data0", 32'(tx_data_o[d]), 32'(exp0_q.pop_front()));
                rise0_q.push_back(cyc);
              end else begin
                chk("frame_data1", 32'(tx_data_o[d]), 32'(exp1_q.pop_front()));
                rise1_q.push_back(cyc);
              end
              tx_active[d] = 1'b1;
              act_cnt[d]   = 10;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    int base;
    logic ok;
    reset = 1'b0;
    wr_en = '0; wr_data = '0; clr_ovf = '0; tx_active = '0; tx_done = '0;
    m_lvl[0] = 0; m_lvl[1] = 0; m_ovf = '0;

    // Reset asserted asynchronously between edges
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_tx_data", 32'(tx_data_o[d]), 32'd0);
      chk("rst_tx_send", 32'(tx_send_o[d]), 32'd0);
      chk("rst_busy", 32'(busy_o[d]), 32'd0);
      chk_fifo(d, "rst");
    end
    @(negedge clk);
    tick();
    reset = 1'b0;
    release_tx(0);
    release_tx(1);
    tick();

    // Single byte: send two clocks after the write, drop one clock after tx_active
    drive(0, 1'b1, 8'hA5, 1'b0);
    chk("single_send_early", 32'(tx_send_o[0]), 32'd0);
    chk("single_level_after_write", 32'(level_o[0]), 32'd1);
    chk("single_empty_after_write", 32'(empty_o[0]), 32'd0);
    tick();
    chk("single_send_rise", 32'(tx_send_o[0]), 32'd1);
    chk("single_tx_data", 32'(tx_data_o[0]), 32'hA5);
    chk("single_level_after_pop", 32'(level_o[0]), 32'd0);
    chk("single_busy", 32'(busy_o[0]), 32'd1);
    tick();
    chk("single_send_fall", 32'(tx_send_o[0]), 32'd0);
    chk("single_data_hold", 32'(tx_data_o[0]), 32'hA5);
    wait_idle(0, "single");
    tick();
    chk("single_busy_end", 32'(busy_o[0]), 32'd0);

    // Ordering and wrap: fill to 16 with transmitter stalled, then drain and top up
    stall(0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1'b1, 8'(i), 1'b0);
      chk_fifo(0, "fill");
    end
    rise0_q.delete();
    exit0_q.delete();
    base = sent_cnt[0];
    release_tx(0);
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (sent_cnt[0] >= base + 4) begin ok = 1'b1; break; end
      tick();
    end
    chk("order_first4", 32'(ok), 32'd1);
    for (int i = 16; i < 20; i++) drive(0, 1'b1, 8'(i), 1'b0);
    wait_idle(0, "order");
    chk("order_count", 32'(sent_cnt[0] - base), 32'd20);
    chk("order_ovf", 32'(overflow_o[0]), 32'd0);
    if (rise0_q.size() > 1 && exit0_q.size() > 0)
      chk("back_to_back", 32'(rise0_q[1] - exit0_q[0]), 32'd1);
    else
      chk("back_to_back_frames", 32'(rise0_q.size()), 32'd20);

    // Overflow: 17 writes into a stalled FIFO, then an 18th together with clr_ovf
    stall(0);
    repeat ($urandom_range(1, 4)) tick();
    for (int i = 0; i < 17; i++) begin
      drive(0, 1'b1, 8'($urandom), 1'b0);
      chk_fifo(0, "ovf_fill");
    end
    drive(0, 1'b1, 8'($urandom), 1'b1);
    chk("ovf_clr_loses", 32'(overflow_o[0]), 32'd1);
    chk_fifo(0, "ovf_concurrent");
    drive(0, 1'b0, 8'h00, 1'b1);
    chk("ovf_cleared", 32'(overflow_o[0]), 32'd0);
    chk_fifo(0, "ovf_after_clear");
    release_tx(0);
    wait_idle(0, "ovf");

    // Push on the pop edge with one byte stored
    stall(0);
    tick();
    b = 8'($urandom);
    drive(0, 1'b1, b, 1'b0);
    chk("pp_setup_level", 32'(level_o[0]), 32'd1);
    release_tx(0);
    drive(0, 1'b1, 8'h3C, 1'b0);
    chk("pp_level", 32'(level_o[0]), 32'd1);
    chk("pp_empty", 32'(empty_o[0]), 32'd0);
    chk("pp_send", 32'(tx_send_o[0]), 32'd1);
    chk("pp_head", 32'(tx_data_o[0]), 32'(b));
    wait_idle(0, "pp");

    // Gap: second frame rises GAP+1 clocks after the first WAIT exit
    rise1_q.delete();
    exit1_q.delete();
    drive(1, 1'b1, 8'($urandom), 1'b0);
    drive(1, 1'b1, 8'($urandom), 1'b0);
    wait_idle(1, "gap");
    if (rise1_q.size() == 2 && exit1_q.size() >= 1)
      chk("gap_spacing", 32'(rise1_q[1] - exit1_q[0]), 32'(GAP + 1));
    else
      chk("gap_frames", 32'(rise1_q.size()), 32'd2);

    // Reset during WAIT of a new burst
    base = sent_cnt[1];
    drive(1, 1'b1, 8'($urandom), 1'b0);
    drive(1, 1'b1, 8'($urandom), 1'b0);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (sent_cnt[1] > base) begin ok = 1'b1; break; end
      tick();
    end
    chk("midrst_first_frame", 32'(ok), 32'd1);
    tick();
    tick();
    tick();
    #2;
    auto_on[1] = 1'b0;
    reset = 1'b1;
    #1;
    exp1_q.delete();
    m_lvl[1] = 0;
    m_ovf[1] = 1'b0;
    release_tx(1);
    auto_on[1] = 1'b0;
    chk("midrst_send", 32'(tx_send_o[1]), 32'd0);
    chk("midrst_busy", 32'(busy_o[1]), 32'd0);
    chk_fifo(1, "midrst");
    @(negedge clk);
    reset = 1'b0;
    auto_on[1] = 1'b1;
    base = sent_cnt[1];
    repeat (40) tick();
    chk("midrst_no_frames", 32'(sent_cnt[1] - base), 32'd0);
    chk_fifo(1, "midrst_after");
    chk("end_exp0_empty", 32'(exp0_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte buffer and send sequencer that sits directly upstream of the UART transmitter unit. Producers push bytes into an internal FIFO. The block pops one byte at a time, presents it on `tx_data`, raises `tx_send`, and waits for the transmitter to complete the frame before it launches the next one. An optional inter-frame idle gap is inserted between frames.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries. Must be a power of two, ≥ 2.
- `ADDR_W`, 4: log2(`DEPTH`).
- `GAP_CYCLES`, 0: idle clocks inserted after each frame completes, before the next pop. 0 means no gap state.

Ports:
- `clk`  in  1: system clock; all logic is rising-edge.
- `reset`  in  1: asynchronous, active-high reset.
- `wr_en`  in  1: push `wr_data` this cycle.
- `wr_data`  in  8: byte to enqueue.
- `clr_ovf`  in  1: synchronous clear of `overflow`.
- `tx_active`  in  1: transmitter frame in progress.
- `tx_done`  in  1: transmitter frame complete.
- `tx_data`  out  8: byte presented to the transmitter; registered.
- `tx_send`  out  1: start request to the transmitter; registered.
- `full`  out  1: level == `DEPTH`.
- `empty`  out  1: level == 0.
- `level`  out  `ADDR_W`+1: number of stored bytes, 0..`DEPTH`.
- `overflow`  out  1: sticky flag; a write was dropped.
- `busy`  out  1: FSM is not in IDLE.

## Operation
- Reset values: `tx_data`=0, `tx_send`=0, `full`=0, `empty`=1, `level`=0, `overflow`=0, `busy`=0, FSM=IDLE. Pointers are cleared. Reset mid-frame discards all FIFO contents and drops `tx_send` immediately.
- FIFO storage:
  - Read and write pointers are `ADDR_W` bits and wrap modulo `DEPTH`.
  - `level` is a separate counter.
  - `full`, `empty` and `level` are registered and reflect the state after the current edge.
- Write rules:
  - Write accepted when `wr_en`=1 and `full`=0.
  - Write when `full`=1 is dropped and sets `overflow`=1 at the next edge. This applies even if a pop occurs in the same cycle.
  - Push and pop in the same cycle (not full): `level` is unchanged.
- `overflow` behaviour:
  - `clr_ovf`=1 clears it.
  - A new overflow in the same cycle as `clr_ovf` wins: the flag stays 1.
- FSM states:
  - IDLE: if `empty`=0 and `tx_active`=0, pop the head into `tx_data`, set `tx_send`=1, and go to SEND.
  - SEND: hold `tx_send`=1 and `tx_data` stable until `tx_active`=1 is sampled. Then clear `tx_send` and go to WAIT. There is no timeout: the FSM waits indefinitely.
  - WAIT: leave when `tx_active`=0 and `tx_done`=1. Go to GAP if `GAP_CYCLES`>0, else to IDLE.
  - GAP: count `GAP_CYCLES` clocks, then go to IDLE.
- `tx_data` holds the last sent byte until the next pop. It is never changed in SEND or WAIT.
- `busy`=1 in SEND, WAIT and GAP.

## Timing
- Write-to-send latency: write at edge N into an empty FIFO with the FSM in IDLE gives `empty`=0 after N, and `tx_send`=1 with valid `tx_data` after N+1. That is 2 clocks.
- The pop occurs on the same edge that asserts `tx_send`. `level` decrements on that edge.
- `tx_send` deasserts on the edge after `tx_active`=1 is first sampled.
- Back-to-back frames (`GAP_CYCLES`=0): the next `tx_send` rises 1 clock after the WAIT exit edge (WAIT→IDLE, then IDLE→SEND).
- With `GAP_CYCLES`=G: the next `tx_send` rises G+1 clocks after the WAIT exit edge.
- A write and a pop in the same cycle with `level`=1: `level` stays 1 and `empty` stays 0.

## Test plan
- Reset and single byte:
  - Stimulus: assert `reset` asynchronously mid-cycle, then write 0xA5. Model the transmitter as `tx_active` high for 10 cycles starting 1 cycle after `tx_send`, then `tx_done` pulses.
  - Required response: all outputs at their reset values during reset. `tx_send` rises 2 clocks after the write with `tx_data`=0xA5 and falls 1 clock after `tx_active` rises. `busy` returns to 0 after `tx_done`.
- Ordering and wrap:
  - Stimulus: `DEPTH`=16; write 0x00..0x0F, then 0x10..0x13 as entries drain.
  - Required response: 20 frames sent in order 0x00..0x13. `full`=1 exactly when `level`=16. No `overflow`.
- Overflow:
  - Stimulus: hold the transmitter busy (`tx_active`=1). Write 17 bytes, then assert `clr_ovf` concurrently with an 18th write.
  - Required response: `level`=16, `overflow`=1 after the 17th write, and it remains 1 after the concurrent clear. A later lone `clr_ovf` clears it. Bytes 17 and 18 are never sent.
- Simultaneous push/pop:
  - Stimulus: `level`=1, FSM in IDLE; write 0x3C on the pop edge.
  - Required response: `level` stays 1, `empty`=0. 0x3C is sent next.
- Gap and reset mid-frame:
  - Stimulus: `GAP_CYCLES`=4; queue 2 bytes. Then, during WAIT of a new burst, assert `reset`.
  - Required response: the second `tx_send` rises 5 clocks after the first frame's WAIT exit. After reset: `level`=0, `tx_send`=0, no further frames sent.
